neopixel_rx: RTL and testbench
==============================

# neopixel_rx

Single-wire WS2812 (NeoPixel) stream decoder: the receive end of the team's NeoPixel transmitter, running in the same ~25 MHz `clk` domain. Samples an asynchronous `din` line, classifies each high pulse as a 0 or 1 bit, and assembles MSB-first 24-bit GRB words. Emits one strobe per pixel with its index, and a frame strobe on the latch (reset) gap. Used for loopback verification of the transmitter and for capturing external pixel chains.

## Interface
- `NUM_LEDS`, 16: pixels accepted per frame; later pixels are dropped.
- `BIT_THRESH`, 15: high-pulse width in clk cycles at or above which the bit decodes as 1 (T0H = 10, T1H = 20 at 25 MHz).
- `RESET_CYCLES`, 1250: din low for this many cycles is a latch gap (50 µs).
- `MIN_HIGH`, 4: shortest legal high pulse. Used only with `NEOPIXEL_RX_ERRCHK_EN`.
- `MAX_LOW`, 125: longest legal inter-bit low time. Used only with `NEOPIXEL_RX_ERRCHK_EN`.
- `clk` in 1: system clock, ~25 MHz.
- `rst` in 1: synchronous, active-high reset.
- `din` in 1: asynchronous serial input.
- `pixel_color` out 24: last completed word, bit 23 = first bit received.
- `pixel_address` out 16: index of `pixel_color` within the frame.
- `pixel_valid` out 1: one-cycle strobe; color and address are valid in this cycle.
- `frame_done` out 1: one-cycle strobe on the latch gap ending an active frame.
- `rx_error` out 1: one-cycle strobe on a timing violation. Tied 0 without the macro.

## Operation
- Input conditioning: `din` passes through a 2-flop synchronizer, then a registered copy for edge detection.
- Reset values: all outputs 0; state SYNC; bit count 0; pixel index 0; counters 0.
- SYNC: waits for the synchronized line to stay low for RESET_CYCLES consecutive cycles, then goes to IDLE. No `frame_done` is generated. A high level restarts the count. This prevents decoding from mid-frame after reset.
- IDLE: pixel index 0, bit count 0. A rising edge moves to HIGH with the high counter cleared.
- HIGH: high counter increments each cycle and saturates at its maximum; it never wraps.
  - On a falling edge, the bit is `high_cnt >= BIT_THRESH`.
  - The bit shifts into the LSB of the 24-bit shift register; the bit count increments; state moves to LOW with the low counter cleared.
- Word complete: when the bit count reaches 24, the block
  - copies the shift register to `pixel_color` and the index to `pixel_address`,
  - pulses `pixel_valid` if the index < NUM_LEDS,
  - increments the index, saturating at NUM_LEDS,
  - clears the bit count.
- Overflow: pixels with index ≥ NUM_LEDS are fully decoded but discarded silently. `pixel_color`/`pixel_address` hold their last values.
- LOW:
  - A rising edge returns to HIGH.
  - If the low counter reaches RESET_CYCLES, the block pulses `frame_done` (only if at least one bit was received this frame) and returns to IDLE.
  - A partial word (bit count ≠ 0) is discarded and never presented.
- Counter widths: `$clog2(RESET_CYCLES+1)` bits, saturating. Bit count is 5 bits, range 0–23. Index is 16 bits.
- `rst` asserted mid-frame: all state and outputs return to reset values in the next cycle; the partial pixel is lost; the block re-enters SYNC.

## Timing
- Latency: a `din` edge first sampled at clk edge k is acted on at edge k+3.
  - `pixel_valid` is high in the cycle following edge k+3, where k samples the 24th falling edge.
  - `frame_done` is high in the cycle after the low counter reaches RESET_CYCLES, i.e. RESET_CYCLES+3 cycles after the last falling edge.
- `pixel_valid` and `frame_done` never assert in the same cycle.
- No back-pressure: the consumer must accept every strobe. The minimum spacing between `pixel_valid` strobes is 24 bit periods.

## Configuration
- `NEOPIXEL_RX_ERRCHK_EN` defined: a timing violation pulses `rx_error` for one cycle, discards the current word, and forces SYNC. Violations are:
  - a high pulse shorter than MIN_HIGH;
  - a low time above MAX_LOW but below RESET_CYCLES at the next rising edge.
  - A frame aborted this way produces no `frame_done`.
- Not defined: no checks; `rx_error` is constant 0; any pulse width is decoded by threshold alone.

## Structure
- `neopixel_pkg` holds:
  - the 25 MHz timing constants (T0H=10, T1H=20, TBIT=32, BIT_THRESH=15, RESET_CYCLES=1250), shared with the transmitter;
  - the state enum typedef {SYNC, IDLE, HIGH, LOW}.
- Sub-module `neopixel_sync_edge`: 2-flop synchronizer plus rise/fall detect, exposing the synchronized level, `rise`, and `fall`.

## Test plan
- Hold `din` low 1300 cycles after `rst`, then send 0xFF0000 (1-bit 20H/12L, 0-bit 10H/22L) -> single `pixel_valid` with color 0xFF0000, address 0.
- Send 3 pixels 0x123456, 0xABCDEF, 0x000001, then 1300 low -> addresses 0,1,2 with matching colors, then one `frame_done`; repeat the frame -> address restarts at 0.
- Send 18 pixels with NUM_LEDS=16 -> exactly 16 `pixel_valid` strobes; `pixel_address` ends at 15.
- Send 10 bits then 1300 low -> no `pixel_valid`, one `frame_done`; the next frame decodes cleanly from address 0.
- Drive `din` high mid-stream at reset release -> nothing is decoded until a 1250-cycle low; assert `rst` mid-pixel -> all outputs 0 next cycle.
- With `NEOPIXEL_RX_ERRCHK_EN`: a 2-cycle high glitch -> `rx_error` pulse, no `pixel_valid`; a 200-cycle low between bits -> `rx_error`, then SYNC.

Source files
------------

// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared WS2812 timing constants and receiver state type
package neopixel_pkg;

    localparam int T0H             = 10;
    localparam int T1H             = 20;
    localparam int TBIT            = 32;
    localparam int NP_BIT_THRESH   = 15;
    localparam int NP_RESET_CYCLES = 1250;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neopixel_rx_if.sv
// rtl/neopixel_rx_if.sv - decoded pixel/frame event bundle from the NeoPixel receiver
interface neopixel_rx_if;
    logic [23:0] pixel_color;
    logic [15:0] pixel_address;
    logic        pixel_valid;
    logic        frame_done;
    logic        rx_error;

    modport master (output pixel_color, pixel_address, pixel_valid, frame_done, rx_error);
    modport slave  (input  pixel_color, pixel_address, pixel_valid, frame_done, rx_error);
endinterface

// File: rtl/neopixel_sync_edge.sv
// rtl/neopixel_sync_edge.sv - 2-flop din synchronizer with registered rise/fall detect
module neopixel_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2;

    // rise/fall are registered so they line up with the registered level copy
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end
endmodule

// File: rtl/neopixel_rx.sv
// rtl/neopixel_rx.sv - WS2812 single-wire decoder; NEOPIXEL_RX_ERRCHK_EN enables timing checks
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int NUM_LEDS     = 16,
    parameter int BIT_THRESH   = NP_BIT_THRESH,
    parameter int RESET_CYCLES = NP_RESET_CYCLES,
    parameter int MIN_HIGH     = 4,
    parameter int MAX_LOW      = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    neopixel_rx_if.master px
);
    // counters must also be able to represent every timing limit they are compared with
    localparam int CNT_W = $clog2(max2(max2(RESET_CYCLES, MAX_LOW), max2(MIN_HIGH, BIT_THRESH)) + 1);

    logic level, rise, fall;

    neopixel_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_t   state;
    logic [CNT_W-1:0] high_cnt, low_cnt;
    logic [4:0]  bit_cnt;
    logic [22:0] shift;
    logic [15:0] pix_idx;
    logic        got_bit;
    logic [23:0] color_r;
    logic [15:0] addr_r;
    logic        valid_r, done_r, err_r;
    logic        bit_v;

    always_comb begin
        bit_v = (high_cnt >= CNT_W'(BIT_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SYNC;
            high_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            pix_idx  <= '0;
            got_bit  <= 1'b0;
            color_r  <= '0;
            addr_r   <= '0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                SYNC: begin
                    if (level) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= CNT_W'(RESET_CYCLES)) begin
                        state   <= IDLE;
                        low_cnt <= '0;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    pix_idx <= '0;
                    bit_cnt <= '0;
                    got_bit <= 1'b0;
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
`ifdef NEOPIXEL_RX_ERRCHK_EN
                        if (high_cnt < CNT_W'(MIN_HIGH)) begin
                            err_r   <= 1'b1;
                            state   <= SYNC;
                            low_cnt <= '0;
                            bit_cnt <= '0;
                        end else
`endif
                        begin
                            shift   <= {shift[21:0], bit_v};
                            got_bit <= 1'b1;
                            state   <= LOW;
                            low_cnt <= '0;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                // pixels past the end of the chain are decoded but dropped
                                if (pix_idx < 16'(NUM_LEDS)) begin
                                    color_r <= {shift, bit_v};
                                    addr_r  <= pix_idx;
                                    valid_r <= 1'b1;
                                    pix_idx <= pix_idx + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else if (high_cnt != '1) begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
`ifdef NEOPIXEL_RX_ERRCHK_EN
                        if (low_cnt > CNT_W'(MAX_LOW)) begin
                            err_r   <= 1'b1;
                            state   <= SYNC;
                            low_cnt <= '0;
                            bit_cnt <= '0;
                        end else
`endif
                        begin
                            state    <= HIGH;
                            high_cnt <= '0;
                        end
                    end else if (low_cnt >= CNT_W'(RESET_CYCLES)) begin
                        done_r <= got_bit;
                        state  <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign px.pixel_color   = color_r;
    assign px.pixel_address = addr_r;
    assign px.pixel_valid   = valid_r;
    assign px.frame_done    = done_r;
    assign px.rx_error      = err_r;
endmodule

// File: tb/tb_neopixel_rx.sv
// tb/tb_neopixel_rx.sv - randomized scoreboard bench for neopixel_rx
module tb_neopixel_rx;
    import neopixel_pkg::*;

    localparam int NUM_LEDS = 16;
    localparam int GAP      = 1300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    neopixel_rx_if bus ();

    neopixel_rx #(.NUM_LEDS(NUM_LEDS)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .px  (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 = pixel, 1 = frame_done, 2 = rx_error
    typedef struct {
        int          kind;
        logic [23:0] color;
        logic [15:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_idx    = 0;
    bit  m_active = 1'b0;
    bit  fixed_t  = 1'b0;
    logic [23:0] ovf_cols [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [23:0] c, input logic [15:0] a);
        ev_t e;
        e.kind  = kind;
        e.color = c;
        e.addr  = a;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d (color 0x%0h addr %0d) expected none",
                     kind, bus.pixel_color, bus.pixel_address);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            n_fail++;
            $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
        end else if (kind == 0 && (bus.pixel_color !== e.color || bus.pixel_address !== e.addr)) begin
            n_fail++;
            $display("FAIL pixel: got 0x%06h@%0d expected 0x%06h@%0d",
                     bus.pixel_color, bus.pixel_address, e.color, e.addr);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_valid && bus.frame_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_overlap: got pixel_valid and frame_done together expected exclusive");
            end
            if (bus.pixel_valid) check_event(0);
            if (bus.frame_done)  check_event(1);
            if (bus.rx_error)    check_event(2);
        end
    end

    task automatic send_bit(input bit b);
        int h, l;
        if (fixed_t) begin
            h = b ? T1H : T0H;
            l = TBIT - h;
        end else begin
            h = b ? int'($urandom_range(24, 18)) : int'($urandom_range(11, 6));
            l = int'($urandom_range(20, 8));
        end
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
        m_active = 1'b1;
    endtask

    task automatic send_pixel(input logic [23:0] c);
        if (m_idx < NUM_LEDS) expect_ev(0, c, m_idx[15:0]);
        m_idx++;
        for (int i = 23; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d events still pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic end_frame();
        if (m_active) expect_ev(1, '0, '0);
        din = 1'b0;
        repeat (GAP) @(negedge clk);
        m_active = 1'b0;
        m_idx    = 0;
        drain();
    endtask

    task automatic resync_low();
        din = 1'b0;
        repeat (GAP) @(negedge clk);
        m_active = 1'b0;
        m_idx    = 0;
        drain();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_color"}, 32'(bus.pixel_color), 32'h0);
        chk({tag, "_addr"},  32'(bus.pixel_address), 32'h0);
        chk({tag, "_valid"}, 32'(bus.pixel_valid), 32'h0);
        chk({tag, "_done"},  32'(bus.frame_done), 32'h0);
        chk({tag, "_err"},   32'(bus.rx_error), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // first pixel after the post-reset sync gap, nominal timing
        resync_low();
        fixed_t = 1'b1;
        send_pixel(24'hFF0000);
        end_frame();
        fixed_t = 1'b0;

        // three-pixel frame twice: address restarts each frame
        repeat (2) begin
            send_pixel(24'h123456);
            send_pixel(24'hABCDEF);
            send_pixel(24'h000001);
            end_frame();
        end

        // overflow: only the first NUM_LEDS pixels are presented
        for (int i = 0; i < 18; i++) begin
            ovf_cols[i] = 24'($urandom);
            send_pixel(ovf_cols[i]);
        end
        end_frame();
        chk("ovf_last_addr",  32'(bus.pixel_address), 32'd15);
        chk("ovf_last_color", 32'(bus.pixel_color), 32'(ovf_cols[15]));

        // partial word only: frame_done without any pixel, then clean frame
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        end_frame();
        send_pixel(24'h00FF7E);
        end_frame();

        // din already toggling at reset release: ignored until a full latch gap
        rst = 1'b1;
        din = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom));
        resync_low();
        send_pixel(24'hC0FFEE);
        end_frame();

        // reset mid-pixel clears all outputs and loses the partial word
        send_pixel(24'h5A5A5A);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        rst = 1'b1;
        din = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        resync_low();
        send_pixel(24'h0F0F0F);
        end_frame();

        // random frames, some ending with a discarded partial word
        for (int f = 0; f < 4; f++) begin
            int np;
            np = int'($urandom_range(4, 1));
            for (int p = 0; p < np; p++) send_pixel(24'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                int nb;
                nb = int'($urandom_range(23, 1));
                for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            end
            end_frame();
        end

`ifdef NEOPIXEL_RX_ERRCHK_EN
        expect_ev(2, '0, '0);
        din = 1'b1;
        repeat (2) @(negedge clk);
        resync_low();

        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        din = 1'b0;
        repeat (200) @(negedge clk);
        expect_ev(2, '0, '0);
        send_bit(1'b1);
        resync_low();
        send_pixel(24'h314159);
        end_frame();
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
